pixel_stream_serializer: RTL and testbench
==========================================

# pixel_stream_serializer

Parametrised successor to the single-word bit shifter in the LED-strip output path. Accepts pixel words (default 24-bit GRB) over a valid/ready handshake and serialises them one bit per `bit_tick` strobe. A one-entry holding buffer lets consecutive words stream with no gap bit. Word and frame boundaries are flagged for the downstream LED bit-timing encoder, and underruns are reported.

## Interface
- `W`, 24: word width in bits; legal range 2..1024. The bit counter width is `$clog2(W)`.
- `MSB_FIRST`, 1: 1 shifts bit W-1 first; 0 shifts bit 0 first.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  synchronous flush; highest priority after `rstn`.
- `in_valid`  in  1  `in_data`/`in_last` are valid.
- `in_ready`  out  1  holding buffer (HB) empty; equals `!hb_full`.
- `in_data`  in  W  pixel word.
- `in_last`  in  1  this word ends the frame.
- `bit_tick`  in  1  one-cycle strobe; advances to the next bit.
- `out`  out  1  current serial bit (registered).
- `out_valid`  out  1  `out` carries a word bit.
- `word_done`  out  1  one-cycle pulse: last bit of a word consumed.
- `frame_done`  out  1  one-cycle pulse: last bit of an `in_last` word consumed.
- `underrun`  out  1  one-cycle pulse: non-last word ended while HB was empty.
- `busy`  out  1  shift register (SR) or HB occupied.

## Operation
- Storage:
  - SR holds the word being shifted plus its last flag.
  - HB holds the next word plus its last flag.
  - `idx` counts bits sent, 0..W-1.
- Accept occurs when `in_valid && in_ready`; HB captures `in_data` and `in_last`.
- There is no bypass. The first word of a burst always passes through HB.
- States:
  - IDLE: SR empty, `out_valid`=0, `out`=0.
  - SHIFT: SR loaded, `out_valid`=1, `out` = current bit.
- IDLE → SHIFT: when HB is full at a clock edge, transfer HB→SR, clear HB, set `idx`=0, and drive `out` = first bit (SR[W-1] or SR[0] per `MSB_FIRST`).
- SHIFT, `bit_tick`=1, `idx`<W-1: shift SR toward the output end, `idx`+1, `out` = next bit.
- SHIFT, `bit_tick`=1, `idx`=W-1 (end of word):
  - `word_done` is pulsed.
  - If the SR last flag is set, `frame_done` is also pulsed.
  - If HB is full: load HB→SR on the same edge, `idx`=0, and stay in SHIFT with no gap cycle.
  - If HB is empty: go to IDLE. If the SR last flag is clear, also pulse `underrun`.
- `bit_tick` in IDLE is ignored.
- `in_ready` is not asserted combinationally on an HB drain. A new accept is possible from the cycle after the drain.
- `clr` takes effect at the next edge:
  - SR and HB are emptied, state goes to IDLE, and all outputs return to reset values.
  - A simultaneous accept or `bit_tick` is discarded.
  - No `word_done`, `frame_done` or `underrun` pulse is generated.
- `busy` = (state==SHIFT) || `hb_full`.

## Timing
- Reset values: `out`=0, `out_valid`=0, `word_done`=0, `frame_done`=0, `underrun`=0, `busy`=0, `in_ready`=1.
- Asserting `rstn` mid-word drops the word immediately (asynchronous). No pulses are generated.
- Latency: accept at edge t → first bit on `out` with `out_valid`=1 after edge t+1.
- Each bit is held until the edge where `bit_tick`=1. A word occupies exactly W ticks.
- `word_done`, `frame_done` and `underrun` are registered and high for the cycle after the final-bit tick edge.
  - That is the same cycle `out` shows the next word's first bit, or the cycle `out_valid` falls.
- With `bit_tick` tied high and HB kept full, `out_valid` stays high continuously.
- `in_valid` held while `in_ready`=0: data is not captured, and the source must hold `in_data`/`in_last` stable.

## Test plan
- Reset, W=24, MSB_FIRST=1, word 0xE15F10 with last=1, `bit_tick` constantly 1:
  - `out` sequence is 1,1,1,0,0,0,0,1,0,1,0,1,1,1,1,1,0,0,0,1,0,0,0,0.
  - `word_done` and `frame_done` pulse once, then IDLE.
- MSB_FIRST=0, word 0x000001: first `out`=1, then 23 zeros.
- Two words 0xFFFFFF then 0x000000 (last) back-to-back, tick every cycle:
  - 48 consecutive `out_valid` cycles.
  - `word_done` pulses at bit 24 and bit 48; `frame_done` pulses only at 48.
- `bit_tick` every 4th cycle: each bit holds 4 cycles. `in_valid` held while `in_ready`=0 is not captured until HB drains.
- Single non-last word, no follow-up: `underrun` and `word_done` pulse together, `out_valid`=0, `busy`=0.
- `clr` at bit 10 with HB full: next cycle `out_valid`=0, `busy`=0, `in_ready`=1, no pulses. Repeat with `rstn` low mid-word and expect the same.

Source files
------------

// File: rtl/pixel_stream_serializer.sv
// Serialises W-bit pixel words one bit per bit_tick through a one-entry holding buffer,
// flagging word/frame ends and underruns for the downstream LED bit-timing encoder.
module pixel_stream_serializer #(
  parameter int W         = 24,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         bit_tick,
  output logic         out,
  output logic         out_valid,
  output logic         word_done,
  output logic         frame_done,
  output logic         underrun,
  output logic         busy
);

  localparam int IDX_W = $clog2(W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [W-1:0]     sr;
  logic             sr_last;
  logic [W-1:0]     hb;
  logic             hb_last;
  logic             hb_full;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     sr_next;
  logic             accept;

  function automatic logic lead_bit(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  // SR always moves toward the output end, so the next bit is the lead bit of the shifted word
  assign sr_next  = MSB_FIRST ? {sr[W-2:0], 1'b0} : {1'b0, sr[W-1:1]};
  assign in_ready = !hb_full;
  assign accept   = in_valid && !hb_full;
  assign busy     = (state == ST_SHIFT) || hb_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      sr         <= '0;
      sr_last    <= 1'b0;
      hb         <= '0;
      hb_last    <= 1'b0;
      hb_full    <= 1'b0;
      idx        <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      word_done  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else if (clr) begin
      state      <= ST_IDLE;
      sr         <= '0;
      sr_last    <= 1'b0;
      hb         <= '0;
      hb_last    <= 1'b0;
      hb_full    <= 1'b0;
      idx        <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      word_done  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      word_done  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;

      if ((state == ST_IDLE && hb_full) ||
          (state == ST_SHIFT && bit_tick && idx == IDX_LAST && hb_full)) begin
        state     <= ST_SHIFT;
        sr        <= hb;
        sr_last   <= hb_last;
        hb_full   <= 1'b0;
        idx       <= '0;
        out       <= lead_bit(hb);
        out_valid <= 1'b1;
      end else if (state == ST_SHIFT && bit_tick && idx == IDX_LAST) begin
        state     <= ST_IDLE;
        out       <= 1'b0;
        out_valid <= 1'b0;
        underrun  <= !sr_last;
      end else if (state == ST_SHIFT && bit_tick) begin
        sr  <= sr_next;
        idx <= idx + 1'b1;
        out <= lead_bit(sr_next);
      end

      if (state == ST_SHIFT && bit_tick && idx == IDX_LAST) begin
        word_done  <= 1'b1;
        frame_done <= sr_last;
      end

      // accept only when HB was already empty before this edge, so a drain never re-fills in the same cycle
      if (accept) begin
        hb      <= in_data;
        hb_last <= in_last;
        hb_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_serializer.sv
// Directed bench for pixel_stream_serializer: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a word/bit-position reference model.
module tb_pixel_stream_serializer;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic bit_tick = 1'b0;

  logic m_ready, m_out, m_ov, m_wd, m_fd, m_ur, m_busy;
  logic l_ready, l_out, l_ov, l_wd, l_fd, l_ur, l_busy;

  always #5 clk = ~clk;

  pixel_stream_serializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(m_ready),
    .in_data(in_data), .in_last(in_last), .bit_tick(bit_tick), .out(m_out),
    .out_valid(m_ov), .word_done(m_wd), .frame_done(m_fd), .underrun(m_ur), .busy(m_busy));

  pixel_stream_serializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(l_ready),
    .in_data(in_data), .in_last(in_last), .bit_tick(bit_tick), .out(l_out),
    .out_valid(l_ov), .word_done(l_wd), .frame_done(l_fd), .underrun(l_ur), .busy(l_busy));

  // reference model: the word on the wire, which bit of it is showing, and the pending word
  bit           e_cur_v, e_hb_v, e_cur_last, e_hb_last, e_wd, e_fd, e_ur, e_acc;
  logic [W-1:0] e_cur_w, e_hb_w;
  int           e_bit;

  always @(posedge clk or negedge rstn) begin
    if (!rstn || clr) begin
      e_cur_v = 0; e_hb_v = 0; e_cur_last = 0; e_hb_last = 0;
      e_cur_w = '0; e_hb_w = '0; e_bit = 0;
      e_wd = 0; e_fd = 0; e_ur = 0;
    end else begin
      e_acc = in_valid && !e_hb_v;
      e_wd = 0; e_fd = 0; e_ur = 0;
      if (!e_cur_v) begin
        if (e_hb_v) begin
          e_cur_v = 1; e_cur_w = e_hb_w; e_cur_last = e_hb_last; e_bit = 0; e_hb_v = 0;
        end
      end else if (bit_tick) begin
        if (e_bit == W - 1) begin
          e_wd = 1;
          e_fd = e_cur_last;
          if (e_hb_v) begin
            e_cur_w = e_hb_w; e_cur_last = e_hb_last; e_bit = 0; e_hb_v = 0;
          end else begin
            e_cur_v = 0;
            e_ur = !e_cur_last;
          end
        end else begin
          e_bit = e_bit + 1;
        end
      end
      if (e_acc) begin
        e_hb_v = 1; e_hb_w = in_data; e_hb_last = in_last;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int tick_div = 1;
  logic seq_msb[$];
  logic seq_lsb[$];
  int wd_cnt = 0, fd_cnt = 0, ur_cnt = 0, wd_ur_cnt = 0, stall_cnt = 0;
  int ov_run = 0, ov_max = 0, last_wd_cyc = 0, wd_gap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    logic exp_m, exp_l;
    @(negedge clk);
    exp_m = e_cur_v ? e_cur_w[W-1-e_bit] : 1'b0;
    exp_l = e_cur_v ? e_cur_w[e_bit] : 1'b0;
    chk("msb_out", m_out, exp_m);
    chk("lsb_out", l_out, exp_l);
    chk("out_valid", m_ov, e_cur_v);
    chk("lsb_out_valid", l_ov, e_cur_v);
    chk("word_done", m_wd, e_wd);
    chk("frame_done", m_fd, e_fd);
    chk("underrun", m_ur, e_ur);
    chk("busy", m_busy, e_cur_v || e_hb_v);
    chk("in_ready", m_ready, !e_hb_v);
    if (m_ov) seq_msb.push_back(m_out);
    if (l_ov) seq_lsb.push_back(l_out);
    if (m_wd) begin
      wd_cnt++;
      wd_gap = cyc_n - last_wd_cyc;
      last_wd_cyc = cyc_n;
    end
    if (m_fd) fd_cnt++;
    if (m_ur) ur_cnt++;
    if (m_wd && m_ur) wd_ur_cnt++;
    if (in_valid && !m_ready) stall_cnt++;
    ov_run = m_ov ? ov_run + 1 : 0;
    if (ov_run > ov_max) ov_max = ov_run;
    @(posedge clk);
    #1;
    cyc_n++;
    bit_tick = (tick_div <= 1) ? 1'b1 : ((cyc_n % tick_div) == 0);
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    for (int i = 0; i < 400; i++) begin
      acc = m_ready;
      cyc();
      if (acc) break;
    end
    chk("send_accepted", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!m_busy) break;
      cyc();
    end
    chk("idle_reached", m_busy, 1'b0);
    cyc();
    cyc();
  endtask

  task automatic fill_to_bit10();
    logic hit;
    hit = 1'b0;
    send(24'hAAAAAA, 1'b0);
    send(24'h555555, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (e_cur_v && e_hb_v && e_bit == 10) begin
        hit = 1'b1;
        break;
      end
      cyc();
    end
    chk("reach_bit10_hb_full", hit, 1'b1);
  endtask

  int exp_seq1[24] = '{1,1,1,0,0,0,0,1,0,1,0,1,1,1,1,1,0,0,0,1,0,0,0,0};
  int base, wd0, fd0, ur0, wu0, ones;

  initial begin
    cyc();
    cyc();
    chk("reset_in_ready", m_ready, 1'b1);
    chk("reset_busy", m_busy, 1'b0);
    chk("reset_out_valid", m_ov, 1'b0);
    rstn = 1'b1;
    cyc();

    // MSB-first frame word, tick every cycle
    base = seq_msb.size(); wd0 = wd_cnt; fd0 = fd_cnt; ur0 = ur_cnt;
    send(24'hE15F10, 1'b1);
    wait_idle(100);
    chk("t1_len", seq_msb.size() - base, 24);
    for (int k = 0; k < 24; k++)
      if (base + k < seq_msb.size()) chk("t1_seq_bit", seq_msb[base + k], exp_seq1[k]);
    chk("t1_word_done_cnt", wd_cnt - wd0, 1);
    chk("t1_frame_done_cnt", fd_cnt - fd0, 1);
    chk("t1_underrun_cnt", ur_cnt - ur0, 0);

    // LSB-first instance: 0x000001 gives a one followed by 23 zeros
    base = seq_lsb.size();
    send(24'h000001, 1'b1);
    wait_idle(100);
    chk("t2_len", seq_lsb.size() - base, 24);
    if (base < seq_lsb.size()) chk("t2_first_bit", seq_lsb[base], 1);
    ones = 0;
    for (int k = 1; k < 24; k++)
      if (base + k < seq_lsb.size() && seq_lsb[base + k]) ones++;
    chk("t2_trailing_ones", ones, 0);

    // two words back to back
    wd0 = wd_cnt; fd0 = fd_cnt; ur0 = ur_cnt; ov_max = 0;
    send(24'hFFFFFF, 1'b0);
    send(24'h000000, 1'b1);
    wait_idle(200);
    chk("t3_valid_run", ov_max, 48);
    chk("t3_word_done_cnt", wd_cnt - wd0, 2);
    chk("t3_frame_done_cnt", fd_cnt - fd0, 1);
    chk("t3_underrun_cnt", ur_cnt - ur0, 0);

    // slow ticks, third word must stall on in_ready
    tick_div = 4;
    wd0 = wd_cnt; stall_cnt = 0;
    send(24'hA5A5A5, 1'b0);
    send(24'h3C3C3C, 1'b0);
    send(24'h0F0F0F, 1'b1);
    chk("t4_stalled", stall_cnt > 0, 1'b1);
    wait_idle(1000);
    chk("t4_word_done_cnt", wd_cnt - wd0, 3);
    chk("t4_word_spacing", wd_gap, 96);
    tick_div = 1;
    cyc();

    // single non-last word
    wd0 = wd_cnt; ur0 = ur_cnt; wu0 = wd_ur_cnt;
    send(24'h123456, 1'b0);
    wait_idle(100);
    chk("t5_underrun_cnt", ur_cnt - ur0, 1);
    chk("t5_wd_ur_together", wd_ur_cnt - wu0, 1);
    chk("t5_out_valid", m_ov, 1'b0);
    chk("t5_busy", m_busy, 1'b0);

    // clr mid-word with HB full
    fill_to_bit10();
    wd0 = wd_cnt; fd0 = fd_cnt; ur0 = ur_cnt;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t6_out_valid", m_ov, 1'b0);
    chk("t6_busy", m_busy, 1'b0);
    chk("t6_in_ready", m_ready, 1'b1);
    chk("t6_pulses", {m_wd, m_fd, m_ur}, 3'b000);
    for (int i = 0; i < 30; i++) cyc();
    chk("t6_no_pulses", (wd_cnt - wd0) + (fd_cnt - fd0) + (ur_cnt - ur0), 0);

    // asynchronous reset mid-word with HB full
    fill_to_bit10();
    wd0 = wd_cnt; fd0 = fd_cnt; ur0 = ur_cnt;
    #2;
    rstn = 1'b0;
    #1;
    chk("t7_out_valid", m_ov, 1'b0);
    chk("t7_busy", m_busy, 1'b0);
    chk("t7_in_ready", m_ready, 1'b1);
    chk("t7_out", m_out, 1'b0);
    cyc();
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    chk("t7_no_pulses", (wd_cnt - wd0) + (fd_cnt - fd0) + (ur_cnt - ur0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
